// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared constants and round-robin helper for reg_share_arb.
package reg_arb_pkg;
  localparam int CNT_W = 16;
  localparam int DEF_NREQ = 4;
  localparam int DEF_DWIDTH = 32;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/reg_share_arb_if.sv
// reg_share_arb_if: requester and downstream signals of reg_share_arb.
// grant_cnt_o exists only when REG_ARB_STATS_EN is defined.
interface reg_share_arb_if import reg_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int DWIDTH = DEF_DWIDTH
);
  localparam int IDXW = $clog2(NREQ);
  logic [NREQ-1:0] req_i;
  logic [NREQ*DWIDTH-1:0] data_i;
  logic [NREQ-1:0] gnt_o;
  logic out_valid_o;
  logic [DWIDTH-1:0] out_data_o;
  logic [IDXW-1:0] owner_o;
  logic out_ready_i;
`ifdef REG_ARB_STATS_EN
  logic [NREQ*CNT_W-1:0] grant_cnt_o;
`endif
  modport slave (
    input req_i, data_i, out_ready_i,
    output gnt_o, out_valid_o, out_data_o, owner_o
`ifdef REG_ARB_STATS_EN
    , output grant_cnt_o
`endif
  );
  modport master (
    output req_i, data_i, out_ready_i,
    input gnt_o, out_valid_o, out_data_o, owner_o
`ifdef REG_ARB_STATS_EN
    , input grant_cnt_o
`endif
  );
endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);
  logic [IDXW-1:0] k;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IDXW'((int'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o = k;
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter sharing one holding register among NREQ requesters.
// Per-requester saturating grant counters are added when REG_ARB_STATS_EN is defined.
module reg_share_arb import reg_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input logic clk,
  input logic rst,
  reg_share_arb_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);
  logic valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic pick_any, can_take, take;
  logic [DWIDTH-1:0] words [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = bus.data_i[g*DWIDTH +: DWIDTH];
  end
  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req_i(bus.req_i),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  always_comb begin
    can_take = !valid_q || bus.out_ready_i;
    take = can_take && pick_any;
    valid_d = take || (valid_q && !bus.out_ready_i);
    data_d = take ? words[pick_idx] : data_q;
    owner_d = take ? pick_idx : owner_q;
    ptr_d = take ? IDXW'(rr_next(int'(pick_idx), NREQ)) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
    end
  end
  // the reset override keeps grants silent while the empty register would otherwise accept
  assign bus.gnt_o = (take && !rst) ? pick_gnt : '0;
  assign bus.out_valid_o = valid_q;
  assign bus.out_data_o = data_q;
  assign bus.owner_o = owner_q;
`ifdef REG_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q[g] <= '0;
      else if (take && pick_gnt[g] && cnt_q[g] != '1) cnt_q[g] <= cnt_q[g] + 1'b1;
    end
    assign bus.grant_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif
endmodule
